// File: rtl/fx2_host_pkg.sv
// Shared types and header encoding for the FX2 host emulator.
// The FPGALink header is the command byte followed by a 4-byte big-endian length.
package fx2_host_pkg;

   localparam int HDR_BYTES = 5;
   localparam logic [2:0] HDR_LAST = 3'(HDR_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      WDATA,
      RDATA
   } state_t;

   function automatic logic [7:0] hdr_byte(
      input logic [2:0]  idx,
      input logic        isRead,
      input logic [6:0]  chan,
      input logic [31:0] len
   );
      case (idx)
         3'd0:    return {isRead, chan};
         3'd1:    return len[31:24];
         3'd2:    return len[23:16];
         3'd3:    return len[15:8];
         3'd4:    return len[7:0];
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/fx2_host_emu.sv
// Host-side FX2 slave-FIFO emulator: turns channel read/write commands into the
// FPGALink byte protocol on EP6OUT and collects read payload from EP8IN.
module fx2_host_emu
   import fx2_host_pkg::*;
#(
   parameter int LEN_WIDTH = 32
) (
   input  logic                 fx2Clk_in,
   input  logic                 fx2Reset_in,
   input  logic                 cmdValid_in,
   output logic                 cmdReady_out,
   input  logic                 cmdIsRead_in,
   input  logic [6:0]           cmdChan_in,
   input  logic [LEN_WIDTH-1:0] cmdLen_in,
   input  logic [7:0]           wrData_in,
   input  logic                 wrValid_in,
   output logic                 wrReady_out,
   output logic [7:0]           rdData_out,
   output logic                 rdValid_out,
   input  logic                 rdReady_in,
   output logic                 busy_out,
   output logic                 err_out,
   input  logic                 fx2FifoSel_in,
   output logic [7:0]           fx2Data_out,
   input  logic [7:0]           fx2Data_in,
   input  logic                 fx2Read_in,
   output logic                 fx2GotData_out,
   input  logic                 fx2Write_in,
   output logic                 fx2GotRoom_out,
   input  logic                 fx2PktEnd_in
);

   state_t                 state;
   logic [2:0]             idx;
   logic                   isRead;
   logic [6:0]             chan;
   logic [LEN_WIDTH-1:0]   len;
   logic [LEN_WIDTH-1:0]   remaining;
   logic                   cmdReadyReg;

   logic ep6Attempt, ep8Attempt, ep6Xfer, ep8Xfer;
   logic unusedPktEnd;

   // Early-commit carries no meaning for a host that always sends exact lengths.
   assign unusedPktEnd = fx2PktEnd_in;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      fx2GotData_out = 1'b0;
      fx2Data_out    = 8'h00;
      case (state)
         HDR: begin
            fx2GotData_out = ~fx2FifoSel_in;
            fx2Data_out    = hdr_byte(idx, isRead, chan, len);
         end
         WDATA: begin
            fx2GotData_out = wrValid_in & ~fx2FifoSel_in;
            fx2Data_out    = wrData_in;
         end
         default: ;
      endcase
   end

   assign ep6Attempt     = ~fx2FifoSel_in & ~fx2Read_in;
   assign ep8Attempt     =  fx2FifoSel_in & ~fx2Write_in;
   assign ep6Xfer        = ep6Attempt & fx2GotData_out;
   assign fx2GotRoom_out = (state == RDATA) & rdReady_in & fx2FifoSel_in;
   assign ep8Xfer        = ep8Attempt & fx2GotRoom_out;

   assign cmdReady_out = cmdReadyReg;
   assign wrReady_out  = (state == WDATA) & ep6Xfer;
   assign busy_out     = (state != IDLE);

   // NOTE: the reset is sampled synchronously, so it lives inside the clocked block rather than in its sensitivity list.
   always_ff @(posedge fx2Clk_in) begin
      if (!fx2Reset_in) begin
         state       <= IDLE;
         idx         <= 3'd0;
         isRead      <= 1'b0;
         chan        <= 7'd0;
         len         <= '0;
         remaining   <= '0;
         cmdReadyReg <= 1'b0;
         rdData_out  <= 8'h00;
         rdValid_out <= 1'b0;
         err_out     <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every read in this block sees the pre-edge value.
         rdValid_out <= 1'b0;

         if ((ep8Attempt && state != RDATA) ||
             (ep6Attempt && (state == IDLE || state == RDATA)))
            err_out <= 1'b1;

         case (state)
            IDLE: begin
               if (cmdValid_in && cmdReadyReg) begin
                  isRead      <= cmdIsRead_in;
                  chan        <= cmdChan_in;
                  len         <= cmdLen_in;
                  idx         <= 3'd0;
                  cmdReadyReg <= 1'b0;
                  state       <= HDR;
               end else begin
                  cmdReadyReg <= 1'b1;
               end
            end
            HDR: begin
               if (ep6Xfer) begin
                  if (idx == HDR_LAST) begin
                     idx       <= 3'd0;
                     remaining <= len;
                     if (len == '0) begin
                        state       <= IDLE;
                        cmdReadyReg <= 1'b1;
                     end else begin
                        state <= isRead ? RDATA : WDATA;
                     end
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end
            WDATA: begin
               if (ep6Xfer) begin
                  remaining <= remaining - 1'b1;
                  if (remaining == LEN_WIDTH'(1)) begin
                     state       <= IDLE;
                     cmdReadyReg <= 1'b1;
                  end
               end
            end
            RDATA: begin
               if (ep8Xfer) begin
                  rdData_out  <= fx2Data_in;
                  rdValid_out <= 1'b1;
                  remaining   <= remaining - 1'b1;
                  if (remaining == LEN_WIDTH'(1)) begin
                     state       <= IDLE;
                     cmdReadyReg <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
